integer_issue_scheduler: RTL and testbench

//  Issue-side counterpart of the integer unit: takes one decoded integer op per cycle (valid/ready),

---
 rtl/integer_issue_scheduler.sv | 123 ++++++++++++
 tb/tb_integer_issue_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/integer_issue_scheduler.sv
// integer_issue_scheduler
//   Registers one decoded integer op per cycle and drives the integer unit's
//   operation/operand/packet/per-unit valid inputs. A writeback-slot
//   reservation vector keeps the fixed-latency sub-units (ALU/BMU/MUL/DIV)
//   from colliding on the shared result bus, and a countdown serialises
//   divisions.
//   data_valid_o bit map: [0] ALU, [1] BMU, [2] MUL, [3] DIV.
//   Optional feature: define ISSUE_STATS_EN to build the stall-cycle counter;
//   otherwise stall_count_o is tied to 0.
module integer_issue_scheduler #(
  parameter int BMU_LATENCY = 1,
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 34,
  parameter int OP_W        = 8,
  parameter int PKT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [1:0]       unit_i,
  input  logic [OP_W-1:0]  operation_i,
  input  logic [31:0]      operand_1_i,
  input  logic [31:0]      operand_2_i,
  input  logic [PKT_W-1:0] ipacket_i,
  input  logic             div_idle_i,
  output logic [OP_W-1:0]  operation_o,
  output logic [31:0]      operand_1_o,
  output logic [31:0]      operand_2_o,
  output logic [PKT_W-1:0] ipacket_o,
  output logic [3:0]       data_valid_o,
  output logic [31:0]      stall_count_o
);

  localparam int OCC_W = DIV_LATENCY;
  localparam int CNT_W = $clog2(DIV_LATENCY + 2);

  localparam logic [OCC_W-1:0] RESV_BMU = OCC_W'(1) << (BMU_LATENCY - 1);
  localparam logic [OCC_W-1:0] RESV_MUL = OCC_W'(1) << (MUL_LATENCY - 1);
  localparam logic [OCC_W-1:0] RESV_DIV = OCC_W'(1) << (DIV_LATENCY - 1);

  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_slot_busy;
  logic [OCC_W-1:0] w_resv;
  logic             w_div_open;
  logic             w_accept;

  // Slot lookup and reservation bit for the offered unit. A DIV result lands
  // one cycle past the tracked horizon, where nothing can already be booked.
  always_comb begin
    w_slot_busy = 1'b0;
    w_resv      = '0;
    case (unit_i)
      2'b00: w_slot_busy = r_occ[0];
      2'b01: begin
        w_slot_busy = r_occ[BMU_LATENCY];
        w_resv      = RESV_BMU;
      end
      2'b10: begin
        w_slot_busy = r_occ[MUL_LATENCY];
        w_resv      = RESV_MUL;
      end
      default: begin
        w_slot_busy = 1'b0;
        w_resv      = RESV_DIV;
      end
    endcase
  end

  assign w_div_open    = (r_div_cnt == '0) & div_idle_i;
  assign issue_ready_o = ~rst_i & ~flush_i & ~w_slot_busy &
                         ((unit_i != 2'b11) | w_div_open);
  assign w_accept      = issue_valid_i & issue_ready_o;

  // Reservation shift, division countdown and registered issue outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_occ        <= '0;
      r_div_cnt    <= '0;
      data_valid_o <= '0;
      operation_o  <= '0;
      operand_1_o  <= '0;
      operand_2_o  <= '0;
      ipacket_o    <= '0;
    end else if (flush_i) begin
      r_occ        <= '0;
      r_div_cnt    <= '0;
      data_valid_o <= '0;
    end else begin
      r_occ <= (r_occ >> 1) | (w_accept ? w_resv : '0);
      if (w_accept && unit_i == 2'b11)
        r_div_cnt <= CNT_W'(DIV_LATENCY + 1);
      else if (r_div_cnt != '0)
        r_div_cnt <= r_div_cnt - 1'b1;
      data_valid_o <= w_accept ? (4'b0001 << unit_i) : 4'b0000;
      if (w_accept) begin
        operation_o <= operation_i;
        operand_1_o <= operand_1_i;
        operand_2_o <= operand_2_i;
        ipacket_o   <= ipacket_i;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  logic [31:0] r_stall_cnt;

  // Cycles where decode offered an op that could not issue; flush is not a stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (issue_valid_i & ~issue_ready_o & ~flush_i)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_count_o = r_stall_cnt;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_integer_issue_scheduler.sv
// Testbench for integer_issue_scheduler: directed scenarios followed by random
// traffic, checked against an absolute-time result-bus booking model.
module tb_integer_issue_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [1:0]  unit_i = 2'b00;
  logic [7:0]  operation_i = '0;
  logic [31:0] operand_1_i = '0;
  logic [31:0] operand_2_i = '0;
  logic [31:0] ipacket_i = '0;
  logic        div_idle_i = 1'b1;
  logic [7:0]  operation_o;
  logic [31:0] operand_1_o;
  logic [31:0] operand_2_o;
  logic [31:0] ipacket_o;
  logic [3:0]  data_valid_o;
  logic [31:0] stall_count_o;

  integer_issue_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .unit_i(unit_i), .operation_i(operation_i),
    .operand_1_i(operand_1_i), .operand_2_i(operand_2_i),
    .ipacket_i(ipacket_i), .div_idle_i(div_idle_i),
    .operation_o(operation_o), .operand_1_o(operand_1_o),
    .operand_2_o(operand_2_o), .ipacket_o(ipacket_o),
    .data_valid_o(data_valid_o), .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: result bus bookings by absolute cycle number, last DIV issue cycle.
  bit          busy[0:8191];
  int          cyc = 0;
  int          last_div = -1000;
  logic [3:0]  exp_dv = '0;
  logic [7:0]  exp_op = '0;
  logic [31:0] exp_o1 = '0;
  logic [31:0] exp_o2 = '0;
  logic [31:0] exp_pkt = '0;
  logic [31:0] exp_stall = '0;

  function automatic int lat_of(input logic [1:0] u);
    case (u)
      2'd0: return 0;
      2'd1: return 1;
      2'd2: return 4;
      default: return 34;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_future();
    for (int i = 0; i < 64; i++) busy[cyc + i] = 1'b0;
    last_div = -1000;
  endtask

  task automatic check_outputs();
    chk("data_valid", data_valid_o, exp_dv);
    chk("operation", operation_o, exp_op);
    chk("operand_1", operand_1_o, exp_o1);
    chk("operand_2", operand_2_o, exp_o2);
    chk("ipacket", ipacket_o, exp_pkt);
    chk("stall_count", stall_count_o, exp_stall);
  endtask

  // One clock cycle: offer inputs, check ready, advance model, check outputs.
  task automatic step(input bit v, input logic [1:0] u, input bit fl,
                      input bit idle, output bit rdy);
    int  lat;
    bit  er;
    bit  acc;
    issue_valid_i = v;
    unit_i        = u;
    flush_i       = fl;
    div_idle_i    = idle;
    operation_i   = 8'($urandom);
    operand_1_i   = $urandom;
    operand_2_i   = $urandom;
    ipacket_i     = $urandom;
    #1;
    lat = lat_of(u);
    er  = !fl && !busy[cyc + 1 + lat] &&
          (u != 2'd3 || (idle && cyc >= last_div + 36));
    rdy = issue_ready_o;
    chk("issue_ready", issue_ready_o, er);
    acc = v && er;
`ifdef ISSUE_STATS_EN
    if (v && !er && !fl) exp_stall = exp_stall + 32'd1;
`endif
    @(posedge clk_i);
    #1;
    if (fl) begin
      cyc++;
      clear_future();
      exp_dv = '0;
    end else begin
      if (acc) begin
        busy[cyc + 1 + lat] = 1'b1;
        if (u == 2'd3) last_div = cyc;
        exp_dv  = 4'b0001 << u;
        exp_op  = operation_i;
        exp_o1  = operand_1_i;
        exp_o2  = operand_2_i;
        exp_pkt = ipacket_i;
      end else begin
        exp_dv = '0;
      end
      cyc++;
    end
    check_outputs();
  endtask

  // Asynchronous reset pulse spanning one clock edge.
  task automatic pulse_reset();
    #2;
    rst_i = 1'b1;
    #1;
    exp_dv = '0; exp_op = '0; exp_o1 = '0; exp_o2 = '0; exp_pkt = '0;
    exp_stall = '0;
    check_outputs();
    chk("ready_in_reset", issue_ready_o, 1'b0);
    @(posedge clk_i);
    cyc++;
    clear_future();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    bit rdy;
    int n;
    logic [31:0] s0;

    // Reset state
    issue_valid_i = 1'b1;
    #1;
    check_outputs();
    chk("ready_in_reset", issue_ready_o, 1'b0);
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd0, 0, 1, rdy);
      chk("alu_b2b_ready", rdy, 1'b1);
    end
    step(0, 2'd0, 0, 1, rdy);

    // MUL then ALU at t+4 blocked, accepted at t+5
    step(1, 2'd2, 0, 1, rdy);
    for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 1, rdy);
    step(1, 2'd0, 0, 1, rdy);
    chk("mul_alu_collide", rdy, 1'b0);
    step(1, 2'd0, 0, 1, rdy);
    chk("mul_alu_after", rdy, 1'b1);
    chk("alu_valid_after_mul", data_valid_o, 4'b0001);

    // DIV serialisation: second DIV waits 35 cycles, stall counter sees them
    step(1, 2'd3, 0, 1, rdy);
    chk("div_first", rdy, 1'b1);
    s0 = stall_count_o;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      step(1, 2'd3, 0, 1, rdy);
      if (!rdy) n++;
    end
    chk("div_stall_cycles", n, 35);
`ifdef ISSUE_STATS_EN
    chk("stall_count_div", stall_count_o - s0, 32'd35);
`else
    chk("stall_count_div", stall_count_o - s0, 32'd0);
`endif
    for (int i = 0; i < 40; i++) step(0, 2'd0, 0, 1, rdy);

    // Three stalled cycles
    step(1, 2'd3, 0, 1, rdy);
    s0 = stall_count_o;
    for (int i = 0; i < 3; i++) step(1, 2'd3, 0, 1, rdy);
`ifdef ISSUE_STATS_EN
    chk("stall_count_3", stall_count_o - s0, 32'd3);
`else
    chk("stall_count_3", stall_count_o - s0, 32'd0);
`endif

    // MUL then flush: ALU accepted every cycle afterwards
    step(1, 2'd2, 0, 1, rdy);
    step(1, 2'd0, 1, 1, rdy);
    chk("flush_ready", rdy, 1'b0);
    chk("flush_valid", data_valid_o, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd0, 0, 1, rdy);
      chk("post_flush_alu", rdy, 1'b1);
    end

    // Reset while DIV and MUL are pending
    step(1, 2'd3, 0, 1, rdy);
    step(1, 2'd2, 0, 1, rdy);
    pulse_reset();
    step(1, 2'd0, 0, 1, rdy);
    chk("post_reset_alu", rdy, 1'b1);
    step(1, 2'd3, 0, 1, rdy);
    chk("post_reset_div", rdy, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 24) == 0, $urandom_range(0, 7) != 0, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
